// File: rtl/server_rx_monitor.sv
// server_rx_monitor: parses fixed-length test frames from the ToR, checks them, and reports per-frame latency plus good/bad frame counters.
// Latency: the result pulse comes one cycle after the terminating tlast beat. A new frame may start on that same cycle.
// Backpressure: none. rx_axis_tready is low only while i_rst is high.
// Ports: i_clk; i_rst (synchronous, active-high); i_time_stamp (free-running local time);
//        rx_axis_* (AXI-Stream sink, tkeep ignored); o_pkt_valid/o_pkt_ok (result pulse and verdict);
//        o_src_tor/o_src_server/o_latency (fields of the last frame, held between results);
//        o_pkt_cnt/o_err_cnt (saturating counters);
//        o_max_latency (present only when SERVER_RX_LAT_MAX_EN is defined).
module server_rx_monitor #(
    parameter logic [47:0] P_MY_PORT_MAC = 48'h8D_BC_5C_4A_00_01,
    parameter int          P_PKT_LEN     = 128
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_time_stamp,
    input  logic        rx_axis_tvalid,
    input  logic [63:0] rx_axis_tdata,
    input  logic        rx_axis_tlast,
    input  logic [7:0]  rx_axis_tkeep,
    input  logic        rx_axis_tuser,
    output logic        rx_axis_tready,
    output logic        o_pkt_valid,
    output logic        o_pkt_ok,
    output logic [2:0]  o_src_tor,
    output logic [2:0]  o_src_server,
    output logic [31:0] o_latency,
    output logic [31:0] o_pkt_cnt,
    output logic [15:0] o_err_cnt
`ifdef SERVER_RX_LAT_MAX_EN
    ,
    output logic [31:0] o_max_latency
`endif
);
    typedef enum logic [1:0] {S_HEAD0, S_HEAD1, S_PAYLOAD, S_DROP} state_t;

    localparam logic [15:0] LAST_IDX = 16'(P_PKT_LEN - 1);
    localparam logic [15:0] ETH_IPV4 = 16'h0800;

    state_t      state;
    logic [15:0] beat_cnt;
    logic        dst_ok_r;
    logic        type_ok_r;
    logic        long_r;
    logic [15:0] src_hi_r;
    logic [31:0] src_lo_r;
    logic [31:0] lat_r;

    logic        accept;
    logic        short_hit;
    logic        ok_nxt;
    logic        dst_ok_nxt;
    logic        type_ok_nxt;
    logic [31:0] src_lo_nxt;
    logic [31:0] lat_nxt;
    logic        unused_bits;

    // The upper source-MAC half is latched with the header but not reported.
    assign unused_bits = ^{rx_axis_tkeep, i_time_stamp[63:32], src_hi_r};

    assign rx_axis_tready = ~i_rst;
    assign accept         = rx_axis_tvalid & rx_axis_tready;

    // Field values as they stand after the current beat.
    // A frame ending on the very beat that carries a field still reports that beat's value.
    always_comb begin
        dst_ok_nxt  = dst_ok_r;
        type_ok_nxt = type_ok_r;
        src_lo_nxt  = src_lo_r;
        lat_nxt     = lat_r;
        if (accept) begin
            case (state)
                S_HEAD0:   dst_ok_nxt = (rx_axis_tdata[63:16] == P_MY_PORT_MAC);
                S_HEAD1: begin
                    src_lo_nxt  = rx_axis_tdata[63:32];
                    type_ok_nxt = (rx_axis_tdata[31:16] == ETH_IPV4);
                end
                // Only the low 32 bits of the difference are kept, so a 32-bit subtract is enough.
                S_PAYLOAD: if (beat_cnt == 16'd2) lat_nxt = i_time_stamp[31:0] - rx_axis_tdata[31:0];
                default:   ;
            endcase
        end
        // An oversized frame already carries long_r in S_DROP, so its tlast is not also counted as short.
        short_hit = accept & rx_axis_tlast & (state != S_DROP) & (beat_cnt < LAST_IDX);
        ok_nxt    = dst_ok_nxt & type_ok_nxt & ~short_hit & ~long_r & ~rx_axis_tuser;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_HEAD0;
            beat_cnt     <= '0;
            dst_ok_r     <= 1'b0;
            type_ok_r    <= 1'b0;
            long_r       <= 1'b0;
            src_hi_r     <= '0;
            src_lo_r     <= '0;
            lat_r        <= '0;
            o_pkt_valid  <= 1'b0;
            o_pkt_ok     <= 1'b0;
            o_src_tor    <= '0;
            o_src_server <= '0;
            o_latency    <= '0;
            o_pkt_cnt    <= '0;
            o_err_cnt    <= '0;
`ifdef SERVER_RX_LAT_MAX_EN
            o_max_latency <= '0;
`endif
        end else begin
            o_pkt_valid <= 1'b0;
            dst_ok_r    <= dst_ok_nxt;
            type_ok_r   <= type_ok_nxt;
            src_lo_r    <= src_lo_nxt;
            lat_r       <= lat_nxt;
            if (accept && state == S_HEAD0) src_hi_r <= rx_axis_tdata[15:0];

            if (accept) begin
                if (rx_axis_tlast) begin
                    // Terminating beat: publish the result and rearm for a frame on the next cycle.
                    state        <= S_HEAD0;
                    beat_cnt     <= '0;
                    long_r       <= 1'b0;
                    o_pkt_valid  <= 1'b1;
                    o_pkt_ok     <= ok_nxt;
                    o_src_tor    <= src_lo_nxt[10:8];
                    o_src_server <= src_lo_nxt[2:0];
                    o_latency    <= lat_nxt;
                    if (ok_nxt) begin
                        if (o_pkt_cnt != '1) o_pkt_cnt <= o_pkt_cnt + 32'd1;
`ifdef SERVER_RX_LAT_MAX_EN
                        if (lat_nxt > o_max_latency) o_max_latency <= lat_nxt;
`endif
                    end else if (o_err_cnt != '1) begin
                        o_err_cnt <= o_err_cnt + 16'd1;
                    end
                end else begin
                    if (beat_cnt != '1) beat_cnt <= beat_cnt + 16'd1;
                    if (state != S_DROP && beat_cnt == LAST_IDX) begin
                        // Expected last beat came without tlast: swallow the rest of the frame.
                        state  <= S_DROP;
                        long_r <= 1'b1;
                    end else begin
                        case (state)
                            S_HEAD0: state <= S_HEAD1;
                            S_HEAD1: state <= S_PAYLOAD;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end
endmodule
